instr_fetch_unit: RTL and testbench

Instruction fetch-and-issue sequencer feeding the 32-bit processor core. Holds a small program memory loaded over a write port. On `start` it walks the program from address 0 and presents each instruction word on `ir_out` under a valid/ready handshake, in the core's IR format (`[31:27]` opertype, `[26:22]` rdst, `[21:17]` rsrc1, `[16]` immemode, `[15:11]` rsrc2, `[15:0]` isrc). It replaces direct IR pokes with a sequenced instruction stream and stops on a HALT opcode or at end of memory.

---
 rtl/instr_fetch_unit_if.sv | 27 ++
 rtl/instr_fetch_unit.sv | 108 ++++++++++
 tb/tb_instr_fetch_unit.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Program-load, start and instruction-issue signals between the fetch unit and
// its host/core; status outputs travel with the issue channel.
interface instr_fetch_unit_if #(
    parameter int AW = 4
) ();
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_data;
    logic          start;
    logic [31:0]   ir_out;
    logic          ir_valid;
    logic          ir_ready;
    logic [AW-1:0] pc;
    logic          busy;
    logic          halted;
    logic [15:0]   issue_cnt;

    modport master (
        input  load_en, load_addr, load_data, start, ir_ready,
        output ir_out, ir_valid, pc, busy, halted, issue_cnt
    );

    modport slave (
        output load_en, load_addr, load_data, start, ir_ready,
        input  ir_out, ir_valid, pc, busy, halted, issue_cnt
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch-and-issue sequencer: walks a loadable program memory from
// address 0 and hands each word to the core under valid/ready, stopping on HALT.
module instr_fetch_unit #(
    parameter int         DEPTH   = 16,
    parameter int         AW      = $clog2(DEPTH),
    parameter logic [4:0] HALT_OP = 5'b11111
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_fetch_unit_if.master  bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FETCH  = 2'd1;
    localparam logic [1:0] S_ISSUE  = 2'd2;
    localparam logic [1:0] S_HALTED = 2'd3;

    logic [31:0]   mem_q [DEPTH];
    logic [1:0]    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [31:0]   ir_q, ir_d;
    logic          valid_q, valid_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          halted_q, halted_d;
    logic [31:0]   fetch_word;
    logic          load_ok;

    assign fetch_word = mem_q[pc_q];
    assign load_ok    = (state_q == S_IDLE) || (state_q == S_HALTED);

    // Program memory is deliberately left out of reset so a program survives rst_n.
    always_ff @(posedge clk) begin
        if (bus.load_en && load_ok) begin
            mem_q[bus.load_addr] <= bus.load_data;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_HALTED: begin
                if (bus.start) begin
                    pc_d    = '0;
                    cnt_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // A HALT word is never latched into ir_out, so ir_out only moves on FETCH->ISSUE.
                if (fetch_word[31:27] == HALT_OP) begin
                    state_d = S_HALTED;
                end else begin
                    ir_d    = fetch_word;
                    valid_d = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (valid_q && bus.ir_ready) begin
                    valid_d = 1'b0;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                    if (pc_q == AW'(DEPTH - 1)) begin
                        state_d = S_HALTED;
                    end else begin
                        pc_d    = pc_q + AW'(1);
                        state_d = S_FETCH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d   = (state_d == S_FETCH) || (state_d == S_ISSUE);
        halted_d = (state_d == S_HALTED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
        end
    end

    assign bus.ir_out    = ir_q;
    assign bus.ir_valid  = valid_q;
    assign bus.pc        = pc_q;
    assign bus.busy      = busy_q;
    assign bus.halted    = halted_q;
    assign bus.issue_cnt = cnt_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: expected issue words are queued as
// programs are loaded and popped by a handshake monitor.
module tb_instr_fetch_unit;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    localparam logic [31:0] W_ADI  = 32'h1005_0004;
    localparam logic [31:0] W_MOVI = 32'h0901_0037;
    localparam logic [31:0] W_HALT = 32'hF800_0000;
    localparam logic [31:0] W_NEW  = 32'hDEAD_BEEF;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   hs_count;
    logic [31:0] exp_q [$];

    instr_fetch_unit_if #(.AW(AW)) bus ();

    instr_fetch_unit #(.DEPTH(DEPTH), .AW(AW), .HALT_OP(5'b11111)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && bus.ir_valid && bus.ir_ready) begin
            logic [31:0] exp_w;
            hs_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL issue_unexpected: got %h, required no issue", bus.ir_out);
            end else begin
                exp_w = exp_q.pop_front();
                if (bus.ir_out !== exp_w) begin
                    errors++;
                    $display("FAIL issue_word: got %h, required %h", bus.ir_out, exp_w);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [AW-1:0] addr, input logic [31:0] data);
        bus.load_en   = 1'b1;
        bus.load_addr = addr;
        bus.load_data = data;
        tick();
        bus.load_en   = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_halted(input int max_cycles, input string name);
        for (int i = 0; i < max_cycles && bus.halted !== 1'b1; i++) tick();
        checks++;
        if (bus.halted !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: halted=%b, required 1 within %0d cycles", name, bus.halted, max_cycles);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.load_en = 1'b0; bus.load_addr = '0; bus.load_data = '0;
        bus.start = 1'b0; bus.ir_ready = 1'b0;
        tick(); tick();
        checks++;
        if ({bus.ir_out, bus.ir_valid, bus.pc, bus.busy, bus.halted, bus.issue_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ir=%h v=%b pc=%0d busy=%b halted=%b cnt=%0d, required all 0",
                     bus.ir_out, bus.ir_valid, bus.pc, bus.busy, bus.halted, bus.issue_cnt);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int hs0;
        load_word(4'd0, W_ADI);
        load_word(4'd1, W_MOVI);
        load_word(4'd2, W_HALT);
        exp_q.push_back(W_ADI);
        exp_q.push_back(W_MOVI);
        hs0 = hs_count;
        bus.ir_ready = 1'b1;
        pulse_start();
        checks++;
        if (bus.busy !== 1'b1 || bus.ir_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_fetch_cycle: busy=%b valid=%b, required busy=1 valid=0", bus.busy, bus.ir_valid);
        end
        tick();
        checks++;
        if (bus.ir_valid !== 1'b1 || bus.pc !== 4'd0) begin
            errors++;
            $display("FAIL basic_first_valid: valid=%b pc=%0d, required valid=1 pc=0", bus.ir_valid, bus.pc);
        end
        wait_halted(40, "basic");
        checks++;
        if (hs_count - hs0 != 2 || bus.issue_cnt !== 16'd2 || bus.pc !== 4'd2 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_end: hs=%0d cnt=%0d pc=%0d busy=%b, required hs=2 cnt=2 pc=2 busy=0",
                     hs_count - hs0, bus.issue_cnt, bus.pc, bus.busy);
        end
    endtask

    task automatic test_backpressure();
        exp_q.push_back(W_ADI);
        exp_q.push_back(W_MOVI);
        bus.ir_ready = 1'b0;
        pulse_start();
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.ir_out !== W_ADI || bus.pc !== 4'd0 || bus.ir_valid !== 1'b1) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: ir=%h pc=%0d valid=%b, required %h 0 1",
                         i, bus.ir_out, bus.pc, bus.ir_valid, W_ADI);
            end
            tick();
        end
        bus.ir_ready = 1'b1;
        wait_halted(40, "backpressure");
        checks++;
        if (bus.issue_cnt !== 16'd2) begin
            errors++;
            $display("FAIL backpressure_cnt: got %0d, required 2", bus.issue_cnt);
        end
    endtask

    task automatic test_load_start();
        int hs0;
        hs0 = hs_count;
        bus.ir_ready = 1'b1;
        bus.load_en = 1'b1; bus.load_addr = 4'd0; bus.load_data = W_HALT;
        bus.start = 1'b1;
        tick();
        bus.load_en = 1'b0; bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.halted !== 1'b0) begin
            errors++;
            $display("FAIL load_start_fetch: busy=%b halted=%b, required 1 0", bus.busy, bus.halted);
        end
        tick();
        checks++;
        if (bus.halted !== 1'b1 || bus.ir_valid !== 1'b0 || bus.issue_cnt !== 16'd0 || hs_count != hs0) begin
            errors++;
            $display("FAIL load_start_halt: halted=%b valid=%b cnt=%0d hs=%0d, required 1 0 0 0",
                     bus.halted, bus.ir_valid, bus.issue_cnt, hs_count - hs0);
        end
    endtask

    task automatic test_end_of_mem();
        int hs0;
        logic [31:0] w;
        for (int i = 0; i < DEPTH; i++) begin
            w = {5'(i % 30), 27'(i * 32'h0012_3457 + 7)};
            load_word(AW'(i), w);
            exp_q.push_back(w);
        end
        hs0 = hs_count;
        bus.ir_ready = 1'b1;
        pulse_start();
        wait_halted(100, "end_of_mem");
        checks++;
        if (hs_count - hs0 != DEPTH || bus.pc !== 4'd15 || bus.issue_cnt !== 16'd16) begin
            errors++;
            $display("FAIL end_of_mem: hs=%0d pc=%0d cnt=%0d, required 16 15 16",
                     hs_count - hs0, bus.pc, bus.issue_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus.ir_valid !== 1'b0 || bus.halted !== 1'b1) begin
                errors++;
                $display("FAIL end_of_mem_no_wrap: valid=%b halted=%b, required 0 1", bus.ir_valid, bus.halted);
            end
        end
    endtask

    task automatic test_load_lockout();
        load_word(4'd0, W_ADI);
        load_word(4'd1, W_MOVI);
        load_word(4'd2, W_HALT);
        exp_q.push_back(W_ADI);
        exp_q.push_back(W_MOVI);
        bus.ir_ready = 1'b0;
        pulse_start();
        tick();
        load_word(4'd1, W_NEW);
        bus.ir_ready = 1'b1;
        wait_halted(40, "lockout");
        checks++;
        if (bus.issue_cnt !== 16'd2) begin
            errors++;
            $display("FAIL lockout_cnt: got %0d, required 2", bus.issue_cnt);
        end
        load_word(4'd1, W_NEW);
        exp_q.push_back(W_ADI);
        exp_q.push_back(W_NEW);
        pulse_start();
        checks++;
        if (bus.issue_cnt !== 16'd0) begin
            errors++;
            $display("FAIL restart_cnt_clear: got %0d, required 0", bus.issue_cnt);
        end
        wait_halted(40, "restart");
        checks++;
        if (bus.issue_cnt !== 16'd2) begin
            errors++;
            $display("FAIL restart_cnt: got %0d, required 2", bus.issue_cnt);
        end
    endtask

    task automatic test_reset_mid();
        bus.ir_ready = 1'b0;
        pulse_start();
        tick();
        checks++;
        if (bus.ir_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre: valid=%b, required 1", bus.ir_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.ir_out, bus.ir_valid, bus.pc, bus.busy, bus.halted, bus.issue_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_async: ir=%h v=%b pc=%0d busy=%b halted=%b cnt=%0d, required all 0",
                     bus.ir_out, bus.ir_valid, bus.pc, bus.busy, bus.halted, bus.issue_cnt);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.halted !== 1'b0 || bus.ir_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b halted=%b valid=%b, required 0 0 0", bus.busy, bus.halted, bus.ir_valid);
        end
        exp_q.push_back(W_ADI);
        exp_q.push_back(W_NEW);
        bus.ir_ready = 1'b1;
        pulse_start();
        wait_halted(40, "reset_rerun");
        checks++;
        if (bus.issue_cnt !== 16'd2 || bus.pc !== 4'd2) begin
            errors++;
            $display("FAIL reset_rerun: cnt=%0d pc=%0d, required 2 2", bus.issue_cnt, bus.pc);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        hs_count = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_load_start();
        test_end_of_mem();
        test_load_lockout();
        test_reset_mid();
        tick(); tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d words left, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
